// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory access controller: request ops, RISC-V
// load/store funct3 values and the controller state encoding.
package mem_ctrl_pkg;

   localparam logic [1:0] OP_FETCH = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE     = 3'd0;
   localparam state_t S_READ     = 3'd1;
   localparam state_t S_RMW_READ = 3'd2;
   localparam state_t S_WRITE    = 3'd3;
   localparam state_t S_RESP     = 3'd4;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling for one memory word: extracts and extends load
// data, and merges sub-word store data into the word read back from memory.
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[{addr_lo, 3'b000} +: 8];
      lane_h = word[{addr_lo[1], 4'b0000} +: 16];

      case (funct3)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_data = {24'h0, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_data = {16'h0, lane_h};
         default: load_data = word;
      endcase

      // Word stores replace the whole word; sub-word stores patch one lane.
      merged = word;
      case (funct3)
         F3_B:    merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
         F3_H:    merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the word-addressed core memory: one fetch/load/store at a time,
// sub-word stores done as read-modify-write, all outputs registered.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [31:0]       mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_data
);

   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic [31:0]       mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;

   logic              req_bad_c;
   logic [31:0]       load_data_c;
   logic [31:0]       merged_c;

   mem_lane_align u_align (
      .word      (mem_data),
      .addr_lo   (addr_lo_q),
      .funct3    (funct3_q),
      .wdata     (wdata_q),
      .load_data (load_data_c),
      .merged    (merged_c)
   );

   // Request legality: op/funct3 encoding, natural alignment, address range.
   always_comb begin
      req_bad_c = 1'b0;
      case (req_op)
         OP_FETCH: req_bad_c = (req_addr[1:0] != 2'b00);
         OP_LOAD: begin
            case (req_funct3)
               F3_B, F3_BU: req_bad_c = 1'b0;
               F3_H, F3_HU: req_bad_c = req_addr[0];
               F3_W:        req_bad_c = (req_addr[1:0] != 2'b00);
               default:     req_bad_c = 1'b1;
            endcase
         end
         OP_STORE: begin
            case (req_funct3)
               F3_B:    req_bad_c = 1'b0;
               F3_H:    req_bad_c = req_addr[0];
               F3_W:    req_bad_c = (req_addr[1:0] != 2'b00);
               default: req_bad_c = 1'b1;
            endcase
         end
         default: req_bad_c = 1'b1;
      endcase
      if (req_addr >= ADDR_LIMIT) begin
         req_bad_c = 1'b1;
      end
   end

   always_comb begin
      state_d          = state_q;
      funct3_d         = funct3_q;
      addr_lo_d        = addr_lo_q;
      wdata_d          = wdata_q;
      resp_err_d       = resp_err_q;
      resp_rdata_d     = resp_rdata_q;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               // Fetches reuse the word-load lane path.
               funct3_d      = (req_op == OP_FETCH) ? F3_W : req_funct3;
               addr_lo_d     = req_addr[1:0];
               wdata_d       = req_wdata;
               mem_address_d = {2'b00, req_addr[31:2]};
               resp_rdata_d  = '0;
               resp_err_d    = 1'b0;
               if (req_bad_c) begin
                  resp_err_d = 1'b1;
                  state_d    = S_RESP;
               end else if (req_op == OP_STORE) begin
                  if (req_funct3 == F3_W) begin
                     mem_write_data_d = req_wdata;
                     state_d          = S_WRITE;
                  end else begin
                     state_d = S_RMW_READ;
                  end
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            resp_rdata_d = load_data_c;
            state_d      = S_RESP;
         end
         S_RMW_READ: begin
            mem_write_data_d = merged_c;
            state_d          = S_WRITE;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Handshake and strobes are registered decodes of the next state.
      req_ready_d  = (state_d == S_IDLE);
      resp_valid_d = (state_d == S_RESP);
      mem_read_d   = (state_d == S_READ) || (state_d == S_RMW_READ);
      mem_write_d  = (state_d == S_WRITE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         funct3_q         <= '0;
         addr_lo_q        <= '0;
         wdata_q          <= '0;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         resp_err_q       <= 1'b0;
         resp_rdata_q     <= '0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         funct3_q         <= funct3_d;
         addr_lo_q        <= addr_lo_d;
         wdata_q          <= wdata_d;
         req_ready_q      <= req_ready_d;
         resp_valid_q     <= resp_valid_d;
         resp_err_q       <= resp_err_d;
         resp_rdata_q     <= resp_rdata_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_err       = resp_err_q;
   assign resp_rdata     = resp_rdata_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 64-word memory behind the DUT and a reference
// model of the architectural load/store results.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_data;

   logic [31:0] mem     [64];
   logic [31:0] ref_mem [64];
   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.DEPTH_WORDS(64), .DATA_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_data       (mem_data)
   );

   // Memory: combinational read, posedge write, writes lost to a coincident reset.
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_idx] <= pre_val;
      else if (mem_write && !reset && mem_address < 32'd64)
         mem[mem_address[5:0]] <= mem_write_data;
   end

   always_comb mem_data = (mem_address < 32'd64) ? mem[mem_address[5:0]] : 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input logic [5:0] idx, input logic [31:0] v);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = idx;
      pre_val = v;
      ref_mem[idx] = v;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Architectural result of one request; updates ref_mem for legal stores.
   task automatic model(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output int lat, output int nrd, output int nwr);
      int unsigned sh;
      logic [31:0] w, v;
      err = 1'b0;
      rd  = 32'h0;
      case (op)
         2'd0: err = (addr % 4) != 0;
         2'd1: begin
            if (f3 == 3'd0 || f3 == 3'd4)      err = 1'b0;
            else if (f3 == 3'd1 || f3 == 3'd5) err = (addr % 2) != 0;
            else if (f3 == 3'd2)               err = (addr % 4) != 0;
            else                               err = 1'b1;
         end
         2'd2: begin
            if (f3 == 3'd0)      err = 1'b0;
            else if (f3 == 3'd1) err = (addr % 2) != 0;
            else if (f3 == 3'd2) err = (addr % 4) != 0;
            else                 err = 1'b1;
         end
         default: err = 1'b1;
      endcase
      if (addr >= 32'd256) err = 1'b1;
      lat = 1; nrd = 0; nwr = 0;
      if (err) return;
      sh = (addr % 4) * 8;
      w  = ref_mem[addr[7:2]];
      v  = w >> sh;
      if (op == 2'd2) begin
         nwr = 1;
         if (f3 == 3'd2) begin
            lat = 2; w = wd;
         end else begin
            lat = 3; nrd = 1;
            if (f3 == 3'd0) w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            else            w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
         end
         ref_mem[addr[7:2]] = w;
      end else begin
         lat = 2; nrd = 1;
         if (op == 2'd0 || f3 == 3'd2) rd = w;
         else if (f3 == 3'd0 || f3 == 3'd4) begin
            rd = v & 32'hFF;
            if (f3 == 3'd0 && rd >= 32'd128) rd = rd | 32'hFFFFFF00;
         end else begin
            rd = v & 32'hFFFF;
            if (f3 == 3'd1 && rd >= 32'd32768) rd = rd | 32'hFFFF0000;
         end
      end
   endtask

   // Issue one request (called at a negedge), check strobes and the response.
   task automatic do_req(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, output int waits);
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat, e_nrd, e_nwr, nrd, nwr, cyc;
      bit          got;
      req_valid  = 1'b1;
      req_op     = op;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      waits = 0;
      while (!req_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!req_ready) begin
         chk("accept_timeout", {31'b0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      model(op, f3, addr, wd, e_err, e_rd, e_lat, e_nrd, e_nwr);
      @(posedge clk);
      nrd = 0; nwr = 0; cyc = 0; got = 1'b0;
      while (!got && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (!hold) req_valid = 1'b0;
         chk("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
         if (mem_read) begin
            nrd++;
            chk("rd_addr", mem_address, {2'b00, addr[31:2]});
         end
         if (mem_write) begin
            nwr++;
            chk("wr_addr", mem_address, {2'b00, addr[31:2]});
         end
         if (resp_valid) got = 1'b1;
      end
      chk("resp_seen", {31'b0, got}, 32'd1);
      chk("latency", 32'(cyc), 32'(e_lat));
      chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
      chk("resp_rdata", resp_rdata, e_rd);
      chk("n_read", 32'(nrd), 32'(e_nrd));
      chk("n_write", 32'(nwr), 32'(e_nwr));
      chk("ready_in_resp", {31'b0, req_ready}, 32'd0);
      if (!e_err && op == 2'd2)
         chk("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
   endtask

   initial begin
      int          w;
      int          r;
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [2:0]  ld_f3 [5];
      logic [2:0]  st_f3 [3];
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      st_f3 = '{3'd0, 3'd1, 3'd2};

      reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_funct3 = 3'd0;
      req_addr = 32'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = 6'd0; pre_val = 32'h0;
      for (int i = 0; i < 64; i++) set_word(6'(i), $urandom);
      reset = 1'b0;

      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
      chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_mem_wdata", mem_write_data, 32'd0);

      // Directed cases
      set_word(6'd4, 32'h00A00093);
      do_req(2'd0, 3'd7, 32'h10, 32'h0, 1'b0, w);
      @(negedge clk);
      chk("resp_pulse_drop", {31'b0, resp_valid}, 32'd0);
      chk("idle_ready", {31'b0, req_ready}, 32'd1);

      set_word(6'd8, 32'h80FF1234);
      do_req(2'd1, 3'd0, 32'h23, 32'h0, 1'b0, w);
      do_req(2'd1, 3'd4, 32'h23, 32'h0, 1'b0, w);
      do_req(2'd1, 3'd5, 32'h22, 32'h0, 1'b0, w);

      set_word(6'd1, 32'h11223344);
      do_req(2'd2, 3'd0, 32'h05, 32'hAB, 1'b0, w);
      chk("sb_word", mem[1], 32'h1122AB44);
      do_req(2'd1, 3'd2, 32'h04, 32'h0, 1'b0, w);

      do_req(2'd1, 3'd2, 32'h06, 32'h0, 1'b0, w);
      do_req(2'd2, 3'd1, 32'h03, 32'h1234, 1'b0, w);
      do_req(2'd1, 3'd2, 32'h100, 32'h0, 1'b0, w);
      do_req(2'd3, 3'd2, 32'h08, 32'h0, 1'b0, w);
      do_req(2'd1, 3'd3, 32'h08, 32'h0, 1'b0, w);

      // Reset during the write cycle of an SH abandons it silently.
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd2; req_funct3 = 3'd1;
      req_addr = 32'h0A; req_wdata = 32'h5555;
      @(posedge clk);
      r = 0;
      do begin
         @(negedge clk);
         req_valid = 1'b0;
         r++;
      end while (!mem_write && r < 6);
      chk("rst_wr_seen", {31'b0, mem_write}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("midrst_ready", {31'b0, req_ready}, 32'd1);
      chk("midrst_mem_read", {31'b0, mem_read}, 32'd0);
      chk("midrst_mem_write", {31'b0, mem_write}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_resp", {31'b0, resp_valid}, 32'd0);
      end
      chk("midrst_mem_word", mem[2], ref_mem[2]);

      // Back-to-back with req_valid held through the busy period.
      do_req(2'd2, 3'd2, 32'h40, 32'hDEADBEEF, 1'b1, w);
      do_req(2'd1, 3'd2, 32'h40, 32'h0, 1'b0, w);
      chk("b2b_wait", 32'(w), 32'd1);
      chk("b2b_word", mem[16], 32'hDEADBEEF);

      // Random traffic against the reference model.
      for (int i = 0; i < 150; i++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0)      addr = $urandom;
         else if (r == 1) addr = 32'h100 + $urandom_range(0, 255);
         else             addr = 32'($urandom_range(0, 255));
         r = int'($urandom_range(0, 15));
         if (r == 0)      op = 2'd3;
         else if (r < 5)  op = 2'd0;
         else if (r < 11) op = 2'd1;
         else             op = 2'd2;
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
         else if (op == 2'd2)           f3 = st_f3[$urandom_range(0, 2)];
         else                           f3 = ld_f3[$urandom_range(0, 4)];
         do_req(op, f3, addr, $urandom, 1'b0, w);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
